// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch program-counter generator.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pc_state_t;

   localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] PC_TRAP_VECTOR  = 32'hBFC0_0180;

endpackage

// File: rtl/pc_gen_pcreg.sv
// PC register: loads the next-PC value every clock, RESET_VECTOR under reset.
module PCReg #(
   parameter int                 D_WIDTH      = 32,
   parameter logic [D_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic               CLK,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] d,
   output logic [D_WIDTH-1:0] q
);

   always_ff @(posedge CLK) begin
      if (rst) q <= RESET_VECTOR;
      else     q <= d;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALTED control, trap and branch redirection with a
// one-entry pending redirect buffer, and a completed-fetch counter.
module pc_gen
   import pc_pkg::*;
#(
   parameter int                 D_WIDTH      = 32,
   parameter logic [D_WIDTH-1:0] RESET_VECTOR = D_WIDTH'(PC_RESET_VECTOR),
   parameter logic [D_WIDTH-1:0] TRAP_VECTOR  = D_WIDTH'(PC_TRAP_VECTOR),
   parameter int                 CNT_WIDTH    = 32
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 fetch_ready,
   input  logic                 branch_taken,
   input  logic [D_WIDTH-1:0]   branch_target,
   input  logic                 trap,
   input  logic                 halt,
   input  logic                 resume,
   output logic [D_WIDTH-1:0]   PC,
   output logic [D_WIDTH-1:0]   PCPlus4,
   output logic                 fetch_valid,
   output logic                 misaligned,
   output logic                 redirect_pending,
   output logic [CNT_WIDTH-1:0] fetch_count
);

   pc_state_t          state;
   logic [D_WIDTH-1:0] pend_target;
   logic [D_WIDTH-1:0] pc_next;
   logic               advance;
   logic               target_bad;
   logic               take_trap;

   assign fetch_valid = (state == RUN);
   // A halt request in RUN freezes the PC on that edge, so it blocks the advance like a stall.
   assign advance     = fetch_valid & fetch_ready & ~stall & ~halt;
   assign target_bad  = branch_taken & (branch_target[1:0] != 2'b00);
   assign take_trap   = trap | target_bad;
   assign PCPlus4     = PC + D_WIDTH'(4);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      pc_next = PC;
      if (take_trap)                        pc_next = TRAP_VECTOR;
      else if (advance && branch_taken)     pc_next = branch_target;
      else if (advance && redirect_pending) pc_next = pend_target;
      else if (advance)                     pc_next = PCPlus4;
   end

   PCReg #(
      .D_WIDTH      (D_WIDTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pcreg (
      .CLK (CLK),
      .rst (rst),
      .d   (pc_next),
      .q   (PC)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state            <= BOOT;
         redirect_pending <= 1'b0;
         pend_target      <= '0;
         misaligned       <= 1'b0;
         fetch_count      <= '0;
      end else begin
         misaligned <= target_bad & ~trap;
         if (advance) fetch_count <= fetch_count + CNT_WIDTH'(1);

         if (take_trap) begin
            redirect_pending <= 1'b0;
            state            <= RUN;
         end else begin
            if (branch_taken && !advance) begin
               redirect_pending <= 1'b1;
               pend_target      <= branch_target;
            end else if (advance) begin
               redirect_pending <= 1'b0;
            end

            case (state)
               BOOT:    state <= RUN;
               RUN:     if (halt) state <= HALTED;
               HALTED:  if (resume && !halt) state <= RUN;
               default: state <= BOOT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand sequences, and
// randomized traffic against a behavioural reference model.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'hBFC0_0000;
   localparam logic [31:0] TV = 32'hBFC0_0180;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        fr;
      logic        bt;
      logic [31:0] tgt;
      logic        trap;
      logic        halt;
      logic        resume;
   } in_t;

   typedef struct {
      in_t         i;
      logic [31:0] pc;
      logic        fv;
      logic        mis;
      logic        rp;
      logic [31:0] cnt;
   } vec_t;

   logic        CLK = 1'b0;
   logic        rst, stall, fetch_ready, branch_taken, trap, halt, resume;
   logic [31:0] branch_target;
   logic [31:0] PC, PCPlus4, fetch_count;
   logic        fetch_valid, misaligned, redirect_pending;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model state; mode 0 = BOOT, 1 = RUN, 2 = HALTED.
   int          m_mode;
   logic [31:0] m_pc, m_pend_t, m_cnt;
   bit          m_pend_v, m_mis;

   pc_gen dut (
      .CLK              (CLK),
      .rst              (rst),
      .stall            (stall),
      .fetch_ready      (fetch_ready),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .trap             (trap),
      .halt             (halt),
      .resume           (resume),
      .PC               (PC),
      .PCPlus4          (PCPlus4),
      .fetch_valid      (fetch_valid),
      .misaligned       (misaligned),
      .redirect_pending (redirect_pending),
      .fetch_count      (fetch_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic in_t mk(input bit r, input bit s, input bit f, input bit b,
                              input logic [31:0] t, input bit tr, input bit h, input bit re);
      in_t v;
      v.rst = r; v.stall = s; v.fr = f; v.bt = b; v.tgt = t;
      v.trap = tr; v.halt = h; v.resume = re;
      return v;
   endfunction

   // Model one clock edge directly from the behavioural rules.
   task automatic model_step(input in_t v);
      bit adv, bad;
      longint unsigned seq;
      if (v.rst) begin
         m_pc = RV; m_mode = 0; m_cnt = 0; m_pend_v = 0; m_mis = 0;
         return;
      end
      adv   = (m_mode == 1) && v.fr && !v.stall && !v.halt;
      bad   = v.bt && (v.tgt % 4 != 0);
      m_mis = bad && !v.trap;
      if (adv) m_cnt = 32'((longint'(m_cnt) + 1) % (64'd1 << 32));
      if (v.trap || bad) begin
         m_pc = TV; m_pend_v = 0; m_mode = 1;
      end else begin
         seq = (longint'(m_pc) + 4) % (64'd1 << 32);
         if (adv) begin
            if (v.bt)          m_pc = v.tgt;
            else if (m_pend_v) m_pc = m_pend_t;
            else               m_pc = 32'(seq);
            m_pend_v = 0;
         end else if (v.bt) begin
            m_pend_v = 1; m_pend_t = v.tgt;
         end
         if (m_mode == 0)                                m_mode = 1;
         else if (m_mode == 1 && v.halt)                 m_mode = 2;
         else if (m_mode == 2 && v.resume && !v.halt)    m_mode = 1;
      end
   endtask

   task automatic drive(input in_t v);
      rst = v.rst; stall = v.stall; fetch_ready = v.fr; branch_taken = v.bt;
      branch_target = v.tgt; trap = v.trap; halt = v.halt; resume = v.resume;
      model_step(v);
      @(posedge CLK);
      #1;
      cyc++;
      check("pc",               PC,                        m_pc);
      check("pcplus4",          PCPlus4,                   m_pc + 32'd4);
      check("fetch_valid",      32'(fetch_valid),          32'(m_mode == 1));
      check("misaligned",       32'(misaligned),           32'(m_mis));
      check("redirect_pending", 32'(redirect_pending),     32'(m_pend_v));
      check("fetch_count",      fetch_count,               m_cnt);
   endtask

   task automatic drive_vec(input vec_t t, input int idx);
      drive(t.i);
      check($sformatf("vec%0d_pc", idx),  PC,                    t.pc);
      check($sformatf("vec%0d_fv", idx),  32'(fetch_valid),      32'(t.fv));
      check($sformatf("vec%0d_mis", idx), 32'(misaligned),       32'(t.mis));
      check($sformatf("vec%0d_rp", idx),  32'(redirect_pending), 32'(t.rp));
      check($sformatf("vec%0d_cnt", idx), fetch_count,           t.cnt);
   endtask

   initial begin
      vec_t tbl[$];
      in_t  v;

      rst = 1; stall = 0; fetch_ready = 0; branch_taken = 0; branch_target = 0;
      trap = 0; halt = 0; resume = 0;
      m_pend_t = 0;

      //            inputs: rst stall fr bt tgt trap halt resume    pc fv mis rp cnt
      tbl.push_back('{mk(1,0,1,0,32'h0,0,0,0),          RV,           0,0,0,0});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          RV,           1,0,0,0});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          RV+4,         1,0,0,1});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          RV+8,         1,0,0,2});
      tbl.push_back('{mk(0,1,1,1,32'h80,0,0,0),         RV+8,         1,0,1,2});
      tbl.push_back('{mk(0,1,1,0,32'h0,0,0,0),          RV+8,         1,0,1,2});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          32'h80,       1,0,0,3});
      tbl.push_back('{mk(0,0,1,1,32'h82,0,0,0),         TV,           1,1,0,4});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          TV+4,         1,0,0,5});
      tbl.push_back('{mk(0,0,0,1,32'h100,1,0,0),        TV,           1,0,0,5});
      tbl.push_back('{mk(0,0,0,0,32'h0,0,0,0),          TV,           1,0,0,5});
      tbl.push_back('{mk(0,0,1,1,32'hFFFF_FFFC,0,0,0),  32'hFFFF_FFFC,1,0,0,6});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          32'h0,        1,0,0,7});
      tbl.push_back('{mk(0,0,0,0,32'h0,0,1,0),          32'h0,        0,0,0,7});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          32'h0,        0,0,0,7});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          32'h0,        0,0,0,7});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          32'h0,        0,0,0,7});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,1),          32'h0,        1,0,0,7});
      tbl.push_back('{mk(0,0,1,0,32'h0,0,0,0),          32'h4,        1,0,0,8});

      foreach (tbl[k]) drive_vec(tbl[k], k);

      // Halt and resume together while HALTED: halt wins.
      drive(mk(0,0,1,0,32'h0,0,1,0));
      drive(mk(0,0,1,0,32'h0,0,1,1));
      check("halt_wins_fv", 32'(fetch_valid), 32'd0);
      check("halt_wins_pc", PC, 32'h4);

      // Reset mid-HALTED with a simultaneous trap: reset wins.
      drive(mk(1,0,1,1,32'h40,1,0,0));
      check("rst_prio_pc",  PC,               RV);
      check("rst_prio_fv",  32'(fetch_valid), 32'd0);
      check("rst_prio_cnt", fetch_count,      32'd0);
      drive(mk(0,0,1,0,32'h0,0,0,0));

      // Pending redirect overwritten by a later request: last one wins.
      drive(mk(0,1,1,1,32'h200,0,0,0));
      drive(mk(0,1,1,1,32'h300,0,0,0));
      check("overwrite_rp", 32'(redirect_pending), 32'd1);
      drive(mk(0,0,1,0,32'h0,0,0,0));
      check("overwrite_pc", PC, 32'h300);
      check("overwrite_rp_clear", 32'(redirect_pending), 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] t;
         case ($urandom_range(0, 9))
            0:       t = 32'hFFFF_FFFC;
            1, 2:    t = $urandom | 32'h1;
            default: t = $urandom & 32'hFFFF_FFFC;
         endcase
         v = mk($urandom_range(0, 99) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 6) == 0,
                t,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) == 0);
         drive(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
